// File: rtl/axis_pixels_shift_multi_pkg.sv
// Shared constants and types for the pixel shift-expander.
// Derived widths and the packed output-beat layout live here.
package pixels_shift_pkg;

  localparam int COPIES      = 2;
  localparam int UNITS       = 4;
  localparam int WORD_WIDTH  = 8;
  localparam int SHIFT_REGS  = 12;
  localparam int KH_MAX      = 5;
  localparam int SH_MAX      = 2;
  localparam int TUSER_WIDTH = 8;
  localparam int I_IS_MAX    = 0;

  localparam int BITS_KH   = $clog2(KH_MAX);
  localparam int BITS_SH   = $clog2(SH_MAX + 1);
  localparam int IN_WIDTH  = SHIFT_REGS * WORD_WIDTH;
  localparam int OUT_WIDTH = COPIES * UNITS * WORD_WIDTH;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef word_t [UNITS-1:0]     copy_t;

  typedef struct packed {
    logic [BITS_KH-1:0]     index;
    logic                   last;
    logic [TUSER_WIDTH-1:0] user;
    copy_t [COPIES-1:0]     data;
  } beat_t;

  // Zero stride would never advance the window, so it behaves as one word.
  function automatic logic [BITS_SH-1:0] eff_stride(input logic [BITS_SH-1:0] s);
    if (s == '0) return BITS_SH'(1);
    if (s > BITS_SH'(SH_MAX)) return BITS_SH'(SH_MAX);
    return s;
  endfunction

  function automatic logic [BITS_KH-1:0] clamp_shift(input logic [BITS_KH-1:0] s);
    return (s > BITS_KH'(KH_MAX - 1)) ? BITS_KH'(KH_MAX - 1) : s;
  endfunction

endpackage

// File: rtl/axis_pixels_shift_multi_if.sv
// Input/output stream bundle of the shift-expander.
// slave is the block's view, master the driver/consumer view.
interface axis_pixels_shift_multi_if;
  import pixels_shift_pkg::*;

  logic                   s_ready;
  logic                   s_valid;
  logic [IN_WIDTH-1:0]    s_data;
  logic [BITS_KH-1:0]     s_shift;
  logic [BITS_SH-1:0]     s_stride;
  logic                   s_ones;
  logic                   s_last;
  logic [TUSER_WIDTH-1:0] s_user;
  logic                   m_ready;
  logic                   m_valid;
  logic [OUT_WIDTH-1:0]   m_data;
  logic [TUSER_WIDTH-1:0] m_user;
  logic                   m_last;
  logic [BITS_KH-1:0]     m_index;

  modport slave (
    input  s_valid, s_data, s_shift, s_stride, s_ones, s_last, s_user, m_ready,
    output s_ready, m_valid, m_data, m_user, m_last, m_index
  );

  modport master (
    output s_valid, s_data, s_shift, s_stride, s_ones, s_last, s_user, m_ready,
    input  s_ready, m_valid, m_data, m_user, m_last, m_index
  );
endinterface

// File: rtl/axis_pixels_shift_multi_skid.sv
// Two-entry AXIS register with a registered s_ready.
// The second entry absorbs the beat in flight when m_ready drops.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  logic             sk_valid;
  logic [WIDTH-1:0] sk_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      sk_valid <= 1'b0;
      sk_data  <= '0;
    end else if (s_ready) begin
      if (m_ready || !m_valid) begin
        m_valid <= s_valid;
        if (s_valid) m_data <= s_data;
      end else if (s_valid) begin
        sk_valid <= 1'b1;
        sk_data  <= s_data;
        s_ready  <= 1'b0;
      end
    end else if (!sk_valid) begin
      s_ready <= 1'b1;
    end else if (m_ready) begin
      m_valid  <= 1'b1;
      m_data   <= sk_data;
      sk_valid <= 1'b0;
      s_ready  <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_pixels_shift_multi.sv
// Shift-expander: one wide input beat becomes (shift+1) output beats,
// each a strided right shift of the word register, sliced or broadcast per copy.
module axis_pixels_shift_multi
  import pixels_shift_pkg::*;
(
  input logic                 aclk,
  input logic                 aresetn,
  axis_pixels_shift_multi_if.slave bus
);

  logic                   clken;
  logic                   accept;
  logic [BITS_KH-1:0]     count;
  logic [BITS_KH-1:0]     phase;
  logic [IN_WIDTH-1:0]    shreg;
  logic [BITS_SH-1:0]     stride;
  logic [TUSER_WIDTH-1:0] user;
  logic                   ones;
  logic                   last;
  logic                   valid1;
  logic                   max_mode;
  logic                   sl_valid;
  beat_t                  sl_next;
  beat_t                  sl_beat;
  beat_t                  out_beat;

  assign bus.s_ready = clken & (count == '0);
  assign accept      = bus.s_valid & bus.s_ready;
  assign max_mode    = user[I_IS_MAX] & ~ones;

  // count is the number of phases still to come; zero means idle or final phase.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count  <= '0;
      phase  <= '0;
      shreg  <= '0;
      stride <= '0;
      user   <= '0;
      ones   <= 1'b0;
      last   <= 1'b0;
      valid1 <= 1'b0;
    end else if (clken) begin
      if (accept) begin
        count  <= clamp_shift(bus.s_shift);
        phase  <= '0;
        shreg  <= bus.s_data;
        stride <= eff_stride(bus.s_stride);
        user   <= bus.s_user;
        ones   <= bus.s_ones;
        last   <= bus.s_last;
        valid1 <= 1'b1;
      end else if (count != '0) begin
        count  <= count - 1'b1;
        phase  <= phase + 1'b1;
        shreg  <= shreg >> (int'(stride) * WORD_WIDTH);
        valid1 <= 1'b1;
      end else begin
        valid1 <= 1'b0;
      end
    end
  end

  // NOTE: sl_next gets a default first so no path through this block infers a latch.
  always_comb begin
    sl_next       = '0;
    sl_next.index = phase;
    sl_next.last  = last & (count == '0);
    sl_next.user  = user;
    for (int c = 0; c < COPIES; c++) begin
      if (c == 0 || max_mode)
        sl_next.data[c] = shreg[c*UNITS*WORD_WIDTH +: UNITS*WORD_WIDTH];
      else
        sl_next.data[c] = shreg[0 +: UNITS*WORD_WIDTH];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sl_valid <= 1'b0;
      sl_beat  <= '0;
    end else if (clken) begin
      sl_valid <= valid1;
      sl_beat  <= sl_next;
    end
  end

  skid_buffer #(.WIDTH($bits(beat_t))) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (sl_valid),
    .s_data  (sl_beat),
    .s_ready (clken),
    .m_valid (bus.m_valid),
    .m_data  (out_beat),
    .m_ready (bus.m_ready)
  );

  assign bus.m_data  = out_beat.data;
  assign bus.m_user  = out_beat.user;
  assign bus.m_last  = out_beat.last;
  assign bus.m_index = out_beat.index;

endmodule

// File: tb/tb_axis_pixels_shift_multi.sv
// Scoreboard bench for axis_pixels_shift_multi: directed beats with
// hand-written expectations, a random backpressure run, and reset mid-burst.
module tb_axis_pixels_shift_multi;
  import pixels_shift_pkg::*;

  typedef struct packed {
    logic [OUT_WIDTH-1:0]   data;
    logic [TUSER_WIDTH-1:0] user;
    logic                   last;
    logic [BITS_KH-1:0]     index;
  } exp_t;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  axis_pixels_shift_multi_if bus ();

  axis_pixels_shift_multi dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rnd_en   = 1'b0;

  always @(posedge aclk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t hb(input logic [31:0] c1, input logic [31:0] c0,
                              input logic [7:0] u, input bit l, input int idx);
    exp_t e;
    e.data  = {c1, c0};
    e.user  = u;
    e.last  = l;
    e.index = BITS_KH'(idx);
    return e;
  endfunction

  // Word-level reference: output word i of phase p is input word i + p*stride, or zero past the top.
  function automatic exp_t model(input logic [IN_WIDTH-1:0] d, input int p, input int es,
                                 input bit mx, input logic [7:0] u, input bit l);
    logic [7:0] w [SHIFT_REGS];
    exp_t e;
    int idx;
    int src;
    for (int i = 0; i < SHIFT_REGS; i++) begin
      idx  = i + p * es;
      w[i] = (idx < SHIFT_REGS) ? d[idx*8 +: 8] : 8'h00;
    end
    e = '0;
    for (int c = 0; c < COPIES; c++)
      for (int k = 0; k < UNITS; k++) begin
        src = (c == 0 || mx) ? c * UNITS + k : k;
        e.data[(c*UNITS+k)*8 +: 8] = w[src];
      end
    e.user  = u;
    e.last  = l;
    e.index = BITS_KH'(p);
    return e;
  endfunction

  task automatic idle();
    bus.s_valid = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge with s_valid still high.
  task automatic send(input logic [IN_WIDTH-1:0] d, input int sh, input int st, input bit ones,
                      input bit lst, input logic [7:0] u, input bit auto_exp);
    bit got;
    int n;
    int es;
    bus.s_data   = d;
    bus.s_shift  = BITS_KH'(sh);
    bus.s_stride = BITS_SH'(st);
    bus.s_ones   = ones;
    bus.s_last   = lst;
    bus.s_user   = u;
    bus.s_valid  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 1000 && !got; k++) begin
      @(negedge aclk);
      got = bus.s_ready;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: s_ready never rose");
      bus.s_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    if (auto_exp) begin
      n  = (sh > KH_MAX - 1) ? KH_MAX - 1 : sh;
      es = (st == 0) ? 1 : ((st > SH_MAX) ? SH_MAX : st);
      for (int p = 0; p <= n; p++)
        exp_q.push_back(model(d, p, es, u[I_IS_MAX] & ~ones, u, lst && (p == n)));
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20000 && exp_q.size() > 0; k++) @(negedge aclk);
    check("drain_left", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    repeat (4) @(negedge aclk);
    @(posedge aclk);
    #1;
  endtask

  initial begin : ready_gen
    bus.m_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      bus.m_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    exp_t cur;
    exp_t held;
    exp_t e;
    bit   stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stalled = 1'b0;
        continue;
      end
      cur = {bus.m_data, bus.m_user, bus.m_last, bus.m_index};
      if (stalled) check("stall_hold", {bus.m_valid, cur}, {1'b1, held});
      if (bus.m_valid && bus.m_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_beat: got %h expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
        stalled = 1'b0;
      end else begin
        stalled = bus.m_valid;
      end
      held = cur;
    end
  end

  initial begin : timeout
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [IN_WIDTH-1:0] d;
    logic [IN_WIDTH-1:0] rd;
    logic [63:0]         s2_tab [KH_MAX];
    int                  a_acc;

    d = 96'h0c0b0a09_08070605_04030201;
    s2_tab[0] = 64'h08070605_04030201;
    s2_tab[1] = 64'h0a090807_06050403;
    s2_tab[2] = 64'h0c0b0a09_08070605;
    s2_tab[3] = 64'h00000c0b_0a090807;
    s2_tab[4] = 64'h00000000_0c0b0a09;

    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_shift = '0; bus.s_stride = '0;
    bus.s_ones  = 1'b0; bus.s_last = 1'b0; bus.s_user = '0;

    #12;
    check("reset_outputs", {bus.m_valid, bus.m_last, bus.m_index, bus.m_data, bus.m_user}, '0);
    check("reset_s_ready", 128'(bus.s_ready), 128'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("s_ready_after_release", 128'(bus.s_ready), 128'(1));

    // Broadcast, stride 1, three phases.
    pop_cyc.delete();
    exp_q.push_back(hb(32'h04030201, 32'h04030201, 8'h00, 0, 0));
    exp_q.push_back(hb(32'h05040302, 32'h05040302, 8'h00, 0, 1));
    exp_q.push_back(hb(32'h06050403, 32'h06050403, 8'h00, 0, 2));
    send(d, 2, 1, 0, 0, 8'h00, 0);
    idle();
    drain();
    check("latency", 128'(pop_cyc[0] - acc_cyc), 128'(2));
    check("throughput", 128'(pop_cyc[2] - pop_cyc[0]), 128'(2));

    // Max-pool slicing, stride 2.
    exp_q.push_back(hb(32'h08070605, 32'h04030201, 8'h01, 0, 0));
    exp_q.push_back(hb(32'h0a090807, 32'h06050403, 8'h01, 0, 1));
    send(d, 1, 2, 0, 0, 8'h01, 0);
    idle();
    drain();

    // Stride 2 over five phases: zero fill from the top, last only on the final phase.
    for (int p = 0; p < KH_MAX; p++)
      exp_q.push_back(hb(s2_tab[p][63:32], s2_tab[p][31:0], 8'h03, p == 4, p));
    send(d, 4, 2, 0, 1, 8'h03, 0);
    idle();
    drain();

    // s_ones forces broadcast in max mode.
    exp_q.push_back(hb(32'h04030201, 32'h04030201, 8'h01, 0, 0));
    send(d, 0, 1, 1, 0, 8'h01, 0);
    idle();
    drain();

    // Stride 0 behaves as 1.
    exp_q.push_back(hb(32'h08070605, 32'h04030201, 8'h01, 0, 0));
    exp_q.push_back(hb(32'h09080706, 32'h05040302, 8'h01, 0, 1));
    send(d, 1, 0, 0, 0, 8'h01, 0);
    idle();
    drain();

    // Stride 3 saturates to 2, shift 7 clamps to 4.
    for (int p = 0; p < KH_MAX; p++)
      exp_q.push_back(hb(s2_tab[p][63:32], s2_tab[p][31:0], 8'h01, p == 4, p));
    send(d, 7, 3, 0, 1, 8'h01, 0);
    idle();
    drain();

    // Back-to-back A then B with s_valid held high.
    pop_cyc.delete();
    exp_q.push_back(hb(32'h04030201, 32'h04030201, 8'h10, 0, 0));
    exp_q.push_back(hb(32'h05040302, 32'h05040302, 8'h10, 0, 1));
    exp_q.push_back(hb(32'h04030201, 32'h04030201, 8'h20, 1, 0));
    send(d, 1, 1, 0, 0, 8'h10, 0);
    a_acc = acc_cyc;
    send(d, 0, 1, 0, 1, 8'h20, 0);
    idle();
    drain();
    check("b2b_accept_gap", 128'(acc_cyc - a_acc), 128'(2));
    check("b2b_no_bubble", 128'(pop_cyc[2] - pop_cyc[0]), 128'(2));

    // Random backpressure with random beats.
    rnd_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rd = {$urandom, $urandom, $urandom};
      send(rd, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom), 1);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge aclk);
        #1;
      end
    end
    idle();
    drain();
    rnd_en = 1'b0;
    @(posedge aclk);
    #1;

    // Reset in the middle of a four-phase beat.
    send(d, 3, 1, 0, 0, 8'h00, 1);
    idle();
    @(posedge aclk);
    #1;
    @(posedge aclk);
    #1;
    check("pre_reset_valid", 128'(bus.m_valid), 128'(1));
    aresetn = 1'b0;
    #1;
    check("reset_m_valid", 128'(bus.m_valid), 128'(0));
    check("reset_mid_s_ready", 128'(bus.s_ready), 128'(0));
    exp_q.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send(96'h1c1b1a19_18171615_14131211, 1, 1, 0, 1, 8'h00, 1);
    idle();
    drain();
    repeat (10) @(negedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pixels_shift_multi.md
Name: axis_pixels_shift_multi

Overview:
- Parametrised shift-expander between the pixel line buffer and the PE array copies.
- Accepts one wide beat of SHIFT_REGS words and emits (s_shift+1) output beats. Each later beat is the register shifted down by a runtime stride of words.
- Output can be sliced per copy (max-pool mode) or broadcast from copy 0.
- Adds stride, tlast and phase-index handling to the existing single-step shift block.

Parameters:
- COPIES, 2, PE array copies on output.
- UNITS, 4, words per copy.
- WORD_WIDTH, 8, bits per pixel word.
- SHIFT_REGS, 12, words held in shift register (>= COPIES*UNITS).
- KH_MAX, 5, max output beats per input beat (s_shift range 0..KH_MAX-1).
- SH_MAX, 2, max stride in words per shift step.
- TUSER_WIDTH, 8, sideband width.
- I_IS_MAX, 0, bit index in s_user selecting max-pool slicing.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- s_ready  out  1  input accepted when s_valid&s_ready.
- s_valid  in  1  input beat valid.
- s_data  in  SHIFT_REGS*WORD_WIDTH  packed words, word 0 in LSBs.
- s_shift  in  clog2(KH_MAX)  extra beats to emit, sampled at acceptance.
- s_stride  in  clog2(SH_MAX+1)  words shifted per step, sampled at acceptance.
- s_ones  in  1  forces broadcast even in max mode.
- s_last  in  1  frame-last marker.
- s_user  in  TUSER_WIDTH  sideband.
- m_ready  in  1  downstream ready.
- m_valid  out  1  output beat valid.
- m_data  out  COPIES*UNITS*WORD_WIDTH  copy c at bits [(c+1)*UNITS*WORD_WIDTH-1 : c*UNITS*WORD_WIDTH].
- m_user  out  TUSER_WIDTH  sideband of the source beat.
- m_last  out  1  s_last of the source beat AND final phase.
- m_index  out  clog2(KH_MAX)  phase number, 0 = unshifted.

Behaviour:
- Reset (async, immediate) clears to 0:
  - all outputs: m_valid, m_last, m_index, m_data, m_user;
  - internal count, phase, registers and skid entries.
  - s_ready is 0 while aresetn is low. After release, s_ready=1 on the first edge that the skid buffer can accept.
- clken = skid buffer s_ready. All internal registers update only when clken=1.
- Counter: count==0 means idle or last phase.
  - s_ready = clken & (count==0).
  - On accept: count <= min(s_shift, KH_MAX-1), phase <= 0.
  - Otherwise, when count!=0 and clken: count <= count-1, phase <= phase+1.
- Shift register:
  - On accept: load s_data.
  - On each non-accept step: shift right by stride*WORD_WIDTH, zero-filling the top words.
  - stride is latched at accept. Stride 0 is treated as 1; stride > SH_MAX saturates to SH_MAX.
- Latched at accept: user, ones, last. They hold constant for all phases of that beat.
- Stage-1 valid:
  - on accept: 1;
  - on a step with count!=0: 1;
  - when idle with clken and no s_valid: 0.
- Slicing:
  - copy 0 = words [UNITS-1:0].
  - copy c>0 = words [(c+1)*UNITS-1 : c*UNITS] if user[I_IS_MAX] & ~ones; otherwise copy 0 is replicated.
- Output via skid buffer: m_last = last & (count==0 at that phase). m_index = phase.
- Latency: accept at edge t → phase-0 beat on m_* after edge t+2 when m_ready stays high.
- Throughput: 1 beat/cycle.
- An input beat with s_shift=N occupies N+1 cycles. The next accept can occur in the cycle where count==0.
- Backpressure: m_ready low stalls once the skid buffer is full; no beat is lost or duplicated. m_data/m_user/m_last/m_index hold stable while m_valid & ~m_ready.
- Simultaneous last-phase step and new s_valid: the new beat is accepted in the same cycle, with no bubble.
- Reset mid-burst: the remaining phases are discarded and the next beat starts at phase 0.

Decomposition:
- Package pixels_shift_pkg: derived widths BITS_KH=clog2(KH_MAX), BITS_SH=clog2(SH_MAX+1), user bit index constants, packed typedefs word_t and copy_t [UNITS-1:0] word_t.
- Sub-module: skid_buffer, the existing two-entry AXIS register, sized COPIES*UNITS*WORD_WIDTH+TUSER_WIDTH+1+BITS_KH.

Test Plan:
- s_data words 0..11 = 1..12, s_shift=2, s_stride=1, broadcast, m_ready=1.
  → 3 beats; copy0/copy1 = {1,2,3,4}, {2,3,4,5}, {3,4,5,6}; m_index 0,1,2; first m_valid 2 cycles after accept.
- Same data, s_user[I_IS_MAX]=1, s_ones=0, s_stride=2, s_shift=1.
  → beat0 copy0={1..4}, copy1={5..8}; beat1 copy0={3..6}, copy1={7..10}.
- s_stride=2, s_shift=4 with SHIFT_REGS=12 → beat 4 has words 8..11 = 9..12 and zero-filled words above.
- Back-to-back beats A (s_shift=1, s_last=0) and B (s_shift=0, s_last=1), s_valid held high.
  → 3 consecutive beats, no bubble; m_last only on B; s_ready high in A's last phase.
- Random m_ready (50%) over 200 beats, random shift/stride.
  → scoreboard matches; outputs stable while stalled; no drops or duplicates.
- Assert aresetn low mid-phase 1 of a 4-phase beat.
  → m_valid=0 immediately; after release, new beat C emits from phase 0 only.
